// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   fwd_sel_e   : Execute operand mux select codes
//   REG_X0      : hard-wired zero register address
//   ex_stage_t  : dependency fields tracked for the instruction in EX
//   wr_stage_t  : write-back fields tracked for the instructions in MEM/WB
//   fwd_select  : forwarding priority for one source operand
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } ex_stage_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
    } wr_stage_t;

    // The younger producer (MEM) wins over the older one (WB); x0 never forwards.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input wr_stage_t  mem,
        input wr_stage_t  wb
    );
        if (mem.regwrite && (mem.rd != REG_X0) && (mem.rd == rs)) begin
            return FWD_MEM;
        end
        if (wb.regwrite && (wb.rd != REG_X0) && (wb.rd == rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the register-dependency fields for the EX, MEM and WB stages.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   bubble     : load an empty entry into EX instead of the Decode fields
//   d_fields   : dependency fields of the instruction in Decode
//   ex_q       : fields of the instruction in EX
//   mem_q      : write-back fields of the instruction in MEM
//   wb_q       : write-back fields of the instruction in WB
module hazard_shadow_pipe
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      bubble,
    input  ex_stage_t d_fields,
    output ex_stage_t ex_q,
    output wr_stage_t mem_q,
    output wr_stage_t wb_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= bubble ? ex_stage_t'('0) : d_fields;
            mem_q <= '{rd: ex_q.rd, regwrite: ex_q.regwrite};
            wb_q  <= mem_q;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and operand forwarding for the 5-stage core, plus
// saturating performance counters for stall and flush events.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_d  : register fields of the Decode instruction
//   valid_d             : Decode holds a real instruction
//   regwrite_d, load_d  : Decode instruction writes rd / is a load
//   branch_taken_e      : the EX instruction redirects the PC
//   forward_a_e/_b_e    : EX operand selects (00 regfile, 01 WB, 10 MEM)
//   stall_f, stall_d    : hold PC / IF-ID register
//   flush_d, flush_e    : clear IF-ID / ID-EX register
//   stall_count         : load-use stall cycles (saturating)
//   flush_count         : taken-branch flush cycles (saturating)
module hazard_unit
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rd_d,
    input  logic        valid_d,
    input  logic        regwrite_d,
    input  logic        load_d,
    input  logic        branch_taken_e,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    ex_stage_t   d_fields;
    ex_stage_t   ex_q;
    wr_stage_t   mem_q;
    wr_stage_t   wb_q;
    logic        load_use;
    logic        bubble;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    assign d_fields = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                        regwrite: regwrite_d, load: load_d};

    hazard_shadow_pipe u_shadow (
        .clk      (clk),
        .rst      (rst),
        .bubble   (bubble),
        .d_fields (d_fields),
        .ex_q     (ex_q),
        .mem_q    (mem_q),
        .wb_q     (wb_q)
    );

    assign load_use = ex_q.load && ex_q.regwrite && (ex_q.rd != REG_X0) && valid_d
                      && ((rs1_d == ex_q.rd) || (rs2_d == ex_q.rd));

    // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
    assign stall_f = load_use && !branch_taken_e;
    assign stall_d = stall_f;
    assign flush_d = branch_taken_e;
    assign flush_e = load_use || branch_taken_e;
    assign bubble  = flush_e || !valid_d;

    assign forward_a_e = fwd_select(ex_q.rs1, mem_q, wb_q);
    assign forward_b_e = fwd_select(ex_q.rs2, mem_q, wb_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (branch_taken_e && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
